// File: rtl/fc_score_producer.sv
// FC output stage: buffers N_IN features, then one MAC per cycle against a 1-cycle ROM; N_IN+2 cycles per neuron (N_IN+3 with FC_BIAS_EN).
// Input backpressure via in_ready (high only while loading); scores held with max_signal until next start or rst.
module fc_score_producer #(
    parameter int N_IN    = 16,
    parameter int NUM_OUT = 10,
    parameter int DATA_W  = 16,
    parameter int FRAC    = 8,
    parameter int ACC_W   = 40,
    parameter int ADDR_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    output logic [ADDR_W-1:0]         w_addr,
    input  logic [DATA_W-1:0]         w_data,
    output logic [NUM_OUT*DATA_W-1:0] outing,
    output logic                      max_signal,
    output logic                      busy
);
    localparam int CNT_W  = $clog2(N_IN);
    localparam int NW     = $clog2(NUM_OUT);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0]  K_LAST = CNT_W'(N_IN - 1);
    localparam logic [NW-1:0]     N_LAST = NW'(NUM_OUT - 1);
    localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(N_IN);
`ifdef FC_BIAS_EN
    localparam logic [ADDR_W-1:0] A_BIAS = ADDR_W'(NUM_OUT * N_IN);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COMPUTE, S_BIAS, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NW-1:0]             n_q, n_d;
    logic [ADDR_W-1:0]         base_q, base_d;
    logic [ADDR_W-1:0]         w_addr_q, w_addr_d;
    logic                      mac_vld_q, mac_vld_d;
    logic                      mac_first_q, mac_first_d;
    logic [CNT_W-1:0]          mac_k_q, mac_k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [NUM_OUT*DATA_W-1:0] outing_q, outing_d;
    logic signed [DATA_W-1:0]  buf_q [N_IN];
`ifdef FC_BIAS_EN
    logic                      bias_vld_q, bias_vld_d;
    logic signed [ACC_W-1:0]   bias_ext;
`endif
    logic                      accept;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   shifted;
    logic [DATA_W-1:0]         score;

    assign accept     = in_valid && (state_q == S_LOAD);
    assign in_ready   = (state_q == S_LOAD);
    assign max_signal = (state_q == S_DONE);
    assign busy       = (state_q == S_LOAD) || (state_q == S_COMPUTE) || (state_q == S_BIAS) ||
                        (state_q == S_DRAIN) || (state_q == S_WRITE);
    assign w_addr     = w_addr_q;
    assign outing     = outing_q;

    // Control: counters, address issue and MAC tagging for the data returning next cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        base_d      = base_q;
        w_addr_d    = w_addr_q;
        mac_vld_d   = 1'b0;
        mac_first_d = 1'b0;
        mac_k_d     = cnt_q;
`ifdef FC_BIAS_EN
        bias_vld_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == K_LAST) begin
                        state_d  = S_COMPUTE;
                        cnt_d    = '0;
                        n_d      = '0;
                        base_d   = '0;
                        w_addr_d = '0;
                    end
                end
            end
            S_COMPUTE: begin
                mac_vld_d   = 1'b1;
                mac_first_d = (cnt_q == '0);
                if (cnt_q == K_LAST) begin
                    cnt_d = '0;
`ifdef FC_BIAS_EN
                    state_d  = S_BIAS;
                    w_addr_d = A_BIAS + ADDR_W'(n_q);
`else
                    state_d  = S_DRAIN;
`endif
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    w_addr_d = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
                end
            end
            S_BIAS: begin
`ifdef FC_BIAS_EN
                bias_vld_d = 1'b1;
`endif
                state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                if (n_q == N_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_COMPUTE;
                    n_d      = n_q + NW'(1);
                    base_d   = base_q + A_STEP;
                    w_addr_d = base_q + A_STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: accumulate, then round toward -inf by the Q8.8 shift and saturate
    always_comb begin
        prod     = buf_q[mac_k_q] * $signed(w_data);
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        acc_d    = acc_q;
        if (mac_vld_q) begin
            acc_d = mac_first_q ? prod_ext : acc_q + prod_ext;
        end
`ifdef FC_BIAS_EN
        bias_ext = {{(ACC_W - DATA_W - FRAC){w_data[DATA_W-1]}}, w_data, {FRAC{1'b0}}};
        if (bias_vld_q) begin
            acc_d = acc_q + bias_ext;
        end
`endif
        shifted = acc_q >>> FRAC;
        if (shifted[ACC_W-1:DATA_W-1] == {(ACC_W - DATA_W + 1){shifted[ACC_W-1]}}) begin
            score = shifted[DATA_W-1:0];
        end else begin
            score = shifted[ACC_W-1] ? {1'b1, {(DATA_W - 1){1'b0}}} : {1'b0, {(DATA_W - 1){1'b1}}};
        end
        outing_d = outing_q;
        if (state_q == S_WRITE) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (n_q == NW'(j)) outing_d[j*DATA_W +: DATA_W] = score;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            w_addr_q    <= '0;
            mac_vld_q   <= 1'b0;
            mac_first_q <= 1'b0;
            mac_k_q     <= '0;
            acc_q       <= '0;
            outing_q    <= '0;
`ifdef FC_BIAS_EN
            bias_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            base_q      <= base_d;
            w_addr_q    <= w_addr_d;
            mac_vld_q   <= mac_vld_d;
            mac_first_q <= mac_first_d;
            mac_k_q     <= mac_k_d;
            acc_q       <= acc_d;
            outing_q    <= outing_d;
`ifdef FC_BIAS_EN
            bias_vld_q  <= bias_vld_d;
`endif
        end
    end

    // Feature buffer is always written before it is read, so it needs no reset
    always_ff @(posedge clk) begin
        if (accept) buf_q[cnt_q] <= in_data;
    end
endmodule

// File: tb/tb_fc_score_producer.sv
// Bench for fc_score_producer (N_IN=4, NUM_OUT=10) with a 1-cycle ROM; honours FC_BIAS_EN.
module tb_fc_score_producer;
    localparam int N_IN = 4, NUM_OUT = 10, DATA_W = 16, FRAC = 8, ACC_W = 40, ADDR_W = 8;
    localparam int OW = NUM_OUT * DATA_W;
`ifdef FC_BIAS_EN
    localparam int          PER_N    = N_IN + 3;
    localparam logic [15:0] BIAS_Q   = 16'h0080;
    localparam bit          HAS_BIAS = 1'b1;
`else
    localparam int          PER_N    = N_IN + 2;
    localparam logic [15:0] BIAS_Q   = 16'h0000;
    localparam bit          HAS_BIAS = 1'b0;
`endif
    localparam int LAT = NUM_OUT * PER_N;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, max_signal, busy;
    logic [DATA_W-1:0] in_data, w_data;
    logic [ADDR_W-1:0] w_addr;
    logic [OW-1:0]     outing;

    fc_score_producer #(.N_IN(N_IN), .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .FRAC(FRAC),
                        .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .w_addr(w_addr), .w_data(w_data), .outing(outing),
        .max_signal(max_signal), .busy(busy));

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    always @(posedge clk) w_data <= rom[w_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    logic [15:0] feat_cur [N_IN];
    logic [15:0] exp_sc [NUM_OUT];

    typedef struct {
        logic [63:0] feats;          // feature k at [k*16 +: 16]
        logic [15:0] w_base, w_step; // weight of neuron n = base + n*step
        logic [6:0]  vpat;           // in_valid pattern, bit 0 first
        int          vlen;
        logic [15:0] e_base, e_step; // expected score n = base + n*step
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact dot product, floor shift by FRAC, clamp to 16-bit signed range
    function automatic logic [15:0] model_score(input int n);
        longint acc;
        acc = 0;
        for (int k = 0; k < N_IN; k++)
            acc += longint'($signed(feat_cur[k])) * longint'($signed(rom[n*N_IN+k]));
        if (HAS_BIAS) acc += longint'($signed(rom[NUM_OUT*N_IN+n])) * 256;
        acc = acc >>> FRAC;
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return acc[15:0];
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_outing0"}, outing, '0);
        check({tag, "_max0"}, OW'(max_signal), '0);
        check({tag, "_rdy0"}, OW'(in_ready), '0);
        check({tag, "_busy0"}, OW'(busy), '0);
        check({tag, "_waddr0"}, OW'(w_addr), '0);
    endtask

    task automatic run_frame(input string tag, input logic [6:0] vpat, input int vlen,
                             input int start_at, input int rst_at);
        logic [OW-1:0] prev_out;
        bit was_done;
        int idx, pi, acc_edge, d, j, n, bad_addr, bad_rdy, seen;
        @(negedge clk);
        prev_out = outing;
        was_done = max_signal;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_rdy_load"}, OW'(in_ready), OW'(1));
        check({tag, "_outing_hold"}, outing, prev_out);
        if (was_done) check({tag, "_max_drop"}, OW'(max_signal), '0);
        idx = 0; pi = 0; acc_edge = -1;
        for (int t = 0; t < 200 && idx < N_IN; t++) begin
            in_valid = vpat[pi % vlen];
            pi++;
            in_data = in_valid ? feat_cur[idx] : 16'($urandom);
            if (in_valid && in_ready) begin
                idx++;
                if (idx == N_IN) acc_edge = cyc + 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (idx != N_IN) begin
            check({tag, "_beats"}, OW'(idx), OW'(N_IN));
            return;
        end
        bad_addr = 0; bad_rdy = 0; seen = -1;
        for (int t = 0; t < LAT + 20; t++) begin
            d = cyc - acc_edge;
            if (max_signal) begin
                seen = d;
                break;
            end
            if (in_ready || !busy) bad_rdy++;
            j = d % PER_N;
            n = d / PER_N;
            if (j < N_IN && int'(w_addr) != n * N_IN + j) bad_addr++;
            if (HAS_BIAS && j == N_IN && int'(w_addr) != NUM_OUT * N_IN + n) bad_addr++;
            start = (d == start_at);
            if (d == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_zero({tag, "_midrst"});
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_latency"}, OW'(seen), OW'(LAT));
        check({tag, "_waddr_seq_errs"}, OW'(bad_addr), '0);
        check({tag, "_rdy_busy_errs"}, OW'(bad_rdy), '0);
        for (int k = 0; k < NUM_OUT; k++)
            check($sformatf("%s_score%0d", tag, k), OW'(outing[k*DATA_W +: DATA_W]), OW'(exp_sc[k]));
        prev_out = outing;
        repeat (3) @(negedge clk);
        check({tag, "_done_hold"}, outing, prev_out);
        check({tag, "_max_hold"}, OW'(max_signal), OW'(1));
    endtask

    task automatic load_row(input int r);
        for (int k = 0; k < N_IN; k++) feat_cur[k] = tbl[r].feats[k*16 +: 16];
        for (int n = 0; n < NUM_OUT; n++) begin
            for (int k = 0; k < N_IN; k++) rom[n*N_IN+k] = tbl[r].w_base + 16'(n) * tbl[r].w_step;
            rom[NUM_OUT*N_IN+n] = BIAS_Q;
            exp_sc[n] = tbl[r].e_base + 16'(n) * tbl[r].e_step;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        tbl[0] = '{64'h0100_0100_0100_0100, 16'h0000, 16'h0100, 7'b0000001, 1, BIAS_Q, 16'h0400};
        tbl[1] = '{64'h7FFF_7FFF_7FFF_7FFF, 16'h7FFF, 16'h0000, 7'b0000001, 1, 16'h7FFF, 16'h0000};
        tbl[2] = '{64'h7FFF_7FFF_7FFF_7FFF, 16'h8000, 16'h0000, 7'b0000001, 1, 16'h8000, 16'h0000};
        tbl[3] = '{64'h0000_0200_FF00_0100, 16'h0100, 16'h0000, 7'b0000001, 1, 16'h0200 + BIAS_Q, 16'h0000};
        tbl[4] = '{64'h0100_0100_0100_0100, 16'h0000, 16'h0100, 7'b1101001, 7, BIAS_Q, 16'h0400};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("idle_rdy", OW'(in_ready), '0);

        for (int r = 0; r < 5; r++) begin
            load_row(r);
            run_frame($sformatf("vec%0d", r), tbl[r].vpat, tbl[r].vlen, -1, -1);
        end

        load_row(0);
        run_frame("start_ignored", 7'b1, 1, 3, -1);
        run_frame("midrst", 7'b1, 1, -1, 5 * PER_N + 2);
        run_frame("after_rst", 7'b1, 1, -1, -1);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N_IN; k++) feat_cur[k] = 16'($urandom);
            for (int a = 0; a < NUM_OUT * N_IN + NUM_OUT; a++) rom[a] = 16'($urandom);
            for (int n = 0; n < NUM_OUT; n++) exp_sc[n] = model_score(n);
            run_frame($sformatf("rand%0d", r), 7'($urandom) | 7'b1, 7, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fc_score_producer.md
Name: fc_score_producer

Overview:
- Sequential output stage of the FC layer. Buffers one input feature vector, then computes NUM_OUT dot products one neuron at a time against weights held in an external synchronous ROM.
- Presents the NUM_OUT 16-bit scores as a packed bus, and asserts a max-valid signal that tells the downstream argmax block the scores are stable.
- Drives the score bus and valid signal that the argmax classifier consumes.

Parameters:
- N_IN, 16, features per input vector
- NUM_OUT, 10, neurons/scores produced
- DATA_W, 16, signed feature/weight/score width, Q8.8
- FRAC, 8, fractional bits
- ACC_W, 40, signed accumulator width
- ADDR_W, 8, weight ROM address width; must hold NUM_OUT*N_IN (+NUM_OUT with bias)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin a new frame; sampled only in IDLE or DONE
- in_valid  in  1  feature beat valid
- in_data  in  DATA_W  signed feature
- in_ready  out  1  high only in LOAD
- w_addr  out  ADDR_W  weight ROM address, registered
- w_data  in  DATA_W  ROM data, valid exactly 1 cycle after w_addr
- outing  out  NUM_OUT*DATA_W  score n at bits [n*DATA_W +: DATA_W]
- max_signal  out  1  scores valid; level
- busy  out  1  high in LOAD/COMPUTE/DRAIN/WRITE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset, at any time including mid-frame:
  - state=IDLE; in_ready=0, w_addr=0, outing=0, max_signal=0, busy=0.
  - Accumulator and counters are cleared.
- States: IDLE, LOAD, COMPUTE, DRAIN, WRITE, DONE.
- IDLE/DONE --start--> LOAD.
  - Leaving DONE deasserts max_signal the next cycle.
  - outing keeps its old values until each score is rewritten.
- LOAD:
  - A beat is accepted when in_valid && in_ready.
  - Beat i goes to buffer[i]; i counts 0..N_IN-1.
  - in_valid gaps stall with no penalty.
  - The accepting edge for beat N_IN-1 moves the state to COMPUTE with n=0.
- COMPUTE:
  - Lasts N_IN cycles.
  - Cycle k issues w_addr = n*N_IN + k.
  - One cycle later: acc += buffer[k]*w_data, as a full-precision signed product sign-extended to ACC_W.
  - The first MAC of a neuron overwrites acc instead of adding to it.
- DRAIN: 1 cycle; performs the final MAC.
- WRITE: 1 cycle.
  - r = acc >>> FRAC (arithmetic).
  - Saturate r to [-32768, 32767]; score n := result.
  - n++; if n==NUM_OUT go to DONE, else go to COMPUTE.
- Per-neuron cost: N_IN+2 cycles.
  - max_signal=1 first visible NUM_OUT*(N_IN+2) cycles after the edge that accepted the last feature; 60 cycles with N_IN=4, NUM_OUT=10.
- DONE: max_signal=1 and outing stable until the next start or rst.
- start outside IDLE/DONE is ignored.
- start and rst asserted together: rst wins.
- w_addr holds its last value outside COMPUTE; w_data is ignored outside the MAC cycles.

Optional Feature:
- Macro: FC_BIAS_EN.
- Defined:
  - After the COMPUTE cycles, one extra issue cycle drives w_addr = NUM_OUT*N_IN + n.
  - The returned bias, sign-extended and shifted left by FRAC, is added to acc before WRITE.
  - Per-neuron cost becomes N_IN+3 cycles.
- Undefined: no bias fetch, no extra cycle, per-neuron cost N_IN+2.

Test Plan:
All tests use N_IN=4 and NUM_OUT=10, with a 1-cycle-latency ROM model.
1. Reset: assert rst for 2 cycles with in_valid=1 and start=1 -> outing=0, max_signal=0, in_ready=0, busy=0.
2. Basic frame: start; features all 0x0100; neuron n weights all n*0x0100 -> score n = n*0x0400 (score 9 = 0x2400); max_signal rises exactly 60 cycles after the last accept; in_ready=0 throughout compute.
3. Saturation: features 0x7FFF with weights 0x7FFF -> every score 0x7FFF; weights 0x8000 -> every score 0x8000; mixed signs features {0x0100,0xFF00,0x0200,0x0000} with weights 0x0100 -> 0x0200.
4. Backpressure: in_valid toggles 1,0,0,1,0,1,1 -> exactly 4 beats captured in order; scores match case 2; w_addr sequence per neuron is n*4+{0,1,2,3}.
5. Mid-frame reset and restart: rst during neuron 5's COMPUTE -> all outputs zero next cycle; a new full frame then completes correctly. start pulsed during COMPUTE -> ignored, with timing unchanged.
6. With FC_BIAS_EN: case 2 stimulus plus bias n = 0x0080 -> score n = n*0x0400 + 0x0080; max_signal at 70 cycles. Back-to-back: start issued in DONE -> max_signal drops next cycle.
